// File: rtl/program_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// program_loader : debounced key-driven writer for the program memory, with fill
// Rev 1.0
// ----------------------------------------------------------------------------
module program_loader #(
  parameter int              DEPTH    = 16,
  parameter int              OP_W     = 4,
  parameter int              DEBOUNCE = 500000,
  parameter logic [OP_W-1:0] FILL_OP  = {OP_W{1'b1}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [OP_W-1:0]              sw_op,
  input  logic                         key_store,
  input  logic                         key_done,
  output logic                         prog_we,
  output logic [$clog2(DEPTH)-1:0]     prog_addr,
  output logic [OP_W-1:0]              prog_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         loaded,
  output logic [1:0]                   state
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int DBW = $clog2(DEBOUNCE+1);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [OP_W-1:0] sw_s1_q, sw_s2_q;
  logic [1:0]      key_raw;
  logic [1:0]      press;

  assign key_raw = {key_done, key_store};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= sw_op;
      sw_s2_q <= sw_s1_q;
    end
  end

  // Index 0 = store key, index 1 = done key; both are active-low pushbuttons.
  for (genvar i = 0; i < 2; i++) begin : g_key
    logic           s1_q, s2_q;
    logic           level_q, level_d;
    logic           press_q, press_d;
    logic [DBW-1:0] cnt_q, cnt_d;

    always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (s2_q != level_q) begin
        if (cnt_q == DBW'(DEBOUNCE-1)) level_d = s2_q;
        else                           cnt_d   = cnt_q + 1'b1;
      end
      press_d = level_q & ~level_d;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1_q    <= 1'b1;
        s2_q    <= 1'b1;
        level_q <= 1'b1;
        cnt_q   <= '0;
        press_q <= 1'b0;
      end else begin
        s1_q    <= key_raw[i];
        s2_q    <= s1_q;
        level_q <= level_d;
        cnt_q   <= cnt_d;
        press_q <= press_d;
      end
    end

    assign press[i] = press_q;
  end

  logic            store_ev, done_ev;
  state_t          state_q, state_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [OP_W-1:0] data_q, data_d;
  logic [CW-1:0]   count_q, count_d;
  logic            loaded_q, loaded_d;
  logic            full_w;

  assign store_ev = press[0];
  assign done_ev  = press[1];
  assign full_w   = (count_q == CW'(DEPTH));

  always_comb begin
    state_d  = state_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    count_d  = count_q;
    loaded_d = loaded_q;
    case (state_q)
      ST_LOAD: begin
        if (done_ev) begin
          if (full_w) begin
            state_d  = ST_DONE;
            loaded_d = 1'b1;
          end else begin
            // First fill write issues on entry so FILL and the writes line up.
            state_d = ST_FILL;
            we_d    = 1'b1;
            addr_d  = count_q[AW-1:0];
            data_d  = FILL_OP;
          end
        end else if (store_ev && !full_w) begin
          we_d    = 1'b1;
          addr_d  = count_q[AW-1:0];
          data_d  = sw_s2_q;
          count_d = count_q + 1'b1;
        end
      end
      ST_FILL: begin
        // The fill pointer is the address just written plus one.
        if (addr_q == AW'(DEPTH-1)) begin
          state_d  = ST_DONE;
          loaded_d = 1'b1;
        end else begin
          we_d   = 1'b1;
          addr_d = addr_q + 1'b1;
          data_d = FILL_OP;
        end
      end
      ST_DONE: begin
        if (done_ev) begin
          state_d  = ST_LOAD;
          count_d  = '0;
          loaded_d = 1'b0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_LOAD;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      count_q  <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      count_q  <= count_d;
      loaded_q <= loaded_d;
    end
  end

  assign prog_we   = we_q;
  assign prog_addr = addr_q;
  assign prog_data = data_q;
  assign count     = count_q;
  assign full      = full_w;
  assign loaded    = loaded_q;
  assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_program_loader : scoreboard bench for program_loader (DEPTH=16, DEBOUNCE=4)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sw_op = 4'h0;
  logic       key_store = 1'b1;
  logic       key_done = 1'b1;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [3:0] prog_data;
  logic [4:0] count;
  logic       full;
  logic       loaded;
  logic [1:0] state;

  program_loader #(.DEPTH(16), .OP_W(4), .DEBOUNCE(4), .FILL_OP(4'hF)) dut (
    .clk(clk), .rst(rst), .sw_op(sw_op), .key_store(key_store), .key_done(key_done),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .count(count), .full(full), .loaded(loaded), .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] addr;
    logic [3:0] data;
    int         cyc;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every write the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    if (rst && prog_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", prog_addr, e.addr);
        check("wr_data", prog_data, e.data);
        check("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // k: 0 = store, 1 = done, 2 = both on the same cycle
  task automatic key_low(input int k, output int d);
    @(posedge clk); #1;
    if (k != 1) key_store = 1'b0;
    if (k != 0) key_done  = 1'b0;
    d = cyc;
  endtask

  task automatic keys_release(input int settle);
    repeat (8) @(posedge clk);
    #1;
    key_store = 1'b1;
    key_done  = 1'b1;
    repeat (settle) @(posedge clk);
  endtask

  task automatic store(input logic [3:0] v, input bit exp_wr, input logic [3:0] exp_addr);
    int  d;
    wr_t w;
    sw_op = v;
    repeat (3) @(posedge clk);
    key_low(0, d);
    if (exp_wr) begin
      w.addr = exp_addr; w.data = v; w.cyc = d + 7;
      exp_q.push_back(w);
    end
    keys_release(12);
  endtask

  task automatic push_fill(input int d, input int first);
    wr_t w;
    for (int a = first; a < 16; a++) begin
      w.addr = 4'(a); w.data = 4'hF; w.cyc = d + 7 + (a - first);
      exp_q.push_back(w);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;

    // Reset held while keys and switches toggle
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      key_store = i[0];
      key_done  = i[1];
      sw_op     = 4'(i);
      @(negedge clk);
      check("rst_outputs", {prog_we, prog_addr, prog_data, count, full, loaded, state}, 0);
    end
    @(posedge clk); #1;
    key_store = 1'b1; key_done = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("post_rst_state", state, 0);
    check("post_rst_count", count, 0);

    // Store sequence
    store(4'h1, 1, 4'h0);
    store(4'h2, 1, 4'h1);
    store(4'h3, 1, 4'h2);
    @(negedge clk);
    check("store_count", count, 3);

    // Glitch shorter than the debounce window
    @(posedge clk); #1 key_store = 1'b0;
    repeat (3) @(posedge clk);
    #1 key_store = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("glitch_count", count, 3);

    // Fill of addresses 3..15
    key_low(1, d);
    push_fill(d, 3);
    wait_cyc(d + 7);
    check("fill_state", state, 1);
    wait_cyc(d + 19);
    check("fill_last_state", state, 1);
    check("fill_last_loaded", loaded, 0);
    wait_cyc(d + 20);
    check("done_state", state, 2);
    check("done_loaded", loaded, 1);
    check("done_count", count, 3);
    keys_release(12);

    store(4'h7, 0, 4'h0);
    @(negedge clk);
    check("done_store_ignored_count", count, 3);
    check("done_store_ignored_state", state, 2);

    key_low(1, d);
    keys_release(12);
    @(negedge clk);
    check("restart_state", state, 0);
    check("restart_count", count, 0);
    check("restart_loaded", loaded, 0);

    // Full: 17 presses, the last ignored
    for (int i = 0; i < 17; i++) begin
      store(4'(i), i < 16, 4'(i));
      if (i == 15) begin
        @(negedge clk);
        check("full_flag", full, 1);
        check("full_count", count, 16);
      end
    end
    @(negedge clk);
    check("sat_count", count, 16);
    check("sat_full", full, 1);

    key_low(1, d);
    wait_cyc(d + 6);
    check("full_done_pre", state, 0);
    wait_cyc(d + 7);
    check("full_done_state", state, 2);
    check("full_done_loaded", loaded, 1);
    keys_release(12);

    key_low(1, d);
    keys_release(12);
    @(negedge clk);
    check("restart2_state", state, 0);
    check("restart2_count", count, 0);

    // Collision: done wins, then reset mid-fill
    store(4'h4, 1, 4'h0);
    store(4'h6, 1, 4'h1);
    sw_op = 4'h5;
    repeat (3) @(posedge clk);
    key_low(2, d);
    push_fill(d, 2);
    wait_cyc(d + 7);
    check("collision_state", state, 1);
    check("collision_count", count, 2);
    wait_cyc(d + 9);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check("midfill_rst_we", prog_we, 0);
    check("midfill_rst_count", count, 0);
    check("midfill_rst_state", state, 0);
    check("abandoned_entries", exp_q.size(), 11);
    exp_q.delete();
    key_store = 1'b1; key_done = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("after_rst_state", state, 0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/program_loader.md
# program_loader

Writer side of the processor's program memory. The program ROM is read by PC. This block lets the operator enter a program at the board: 4-bit opcodes on switches, committed with a store key, sequentially written into the program memory write port. On completion, unused locations are padded with a fill opcode and `loaded` is raised so the processor can run.

## Interface
- `DEPTH`, 16: program memory locations; address width is 4.
- `OP_W`, 4: opcode width.
- `DEBOUNCE`, 500000: consecutive stable cycles required to accept a key level (10 ms at 50 MHz); benches use 4.
- `FILL_OP`, 4'hF: opcode written into unused locations.
- `clk`  in  1  system clock (CLOCK_50); single clock domain.
- `rst`  in  1  reset, asynchronous, active-low.
- `sw_op`  in  OP_W  opcode from switches; asynchronous, 2-FF synchronized.
- `key_store`  in  1  raw pushbutton, active-low; press commits `sw_op`.
- `key_done`  in  1  raw pushbutton, active-low; press ends loading or restarts.
- `prog_we`  out  1  program memory write strobe, one cycle per write.
- `prog_addr`  out  4  write address.
- `prog_data`  out  OP_W  write data.
- `count`  out  5  user opcodes stored, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `loaded`  out  1  program complete; high only in DONE.
- `state`  out  2  LOAD=0, FILL=1, DONE=2 (for LEDG).

## Operation
- Reset (async, any state) forces these values:
  - `prog_we`, `prog_addr`, `prog_data`, `count`, `full`, `loaded` = 0.
  - `state` = LOAD.
  - Debounce counters = 0; debounced key levels = 1 (released).
- Key conditioning (each key independently):
  - 2-FF synchronizer.
  - The debounced level takes the synced value after the synced value has differed from it for DEBOUNCE consecutive cycles.
  - Any cycle of agreement clears the counter.
  - Press event = 1-cycle pulse on a debounced 1->0 transition.
  - Releases generate nothing.
- LOAD:
  - A store event with `count < DEPTH` registers `prog_we`=1, `prog_addr`=`count`[3:0], `prog_data`=synced `sw_op`, and `count`+1.
  - A store event with `full`=1 is ignored. `count` saturates at DEPTH; no wrap.
  - A done event with `count == DEPTH` goes straight to DONE.
  - A done event with `count < DEPTH` goes to FILL, with the fill pointer set to `count`.
  - Store and done events in the same cycle: done wins; the store is dropped and nothing is written.
- FILL:
  - Each cycle, write `FILL_OP` at the fill pointer, then increment the pointer.
  - After the write to address DEPTH-1, go to DONE.
  - `count` is unchanged. All key events are ignored.
- DONE:
  - `loaded`=1.
  - Store events are ignored.
  - A done event returns to LOAD with `count`=0, `loaded`=0, and no writes.
  - Memory contents are not cleared; they are overwritten on the next load.
- `full` is combinational from `count`. All other outputs are registered.

## Timing
- Raw key falling edge, held low, to `prog_we` high: DEBOUNCE+3 cycles (2 sync, DEBOUNCE count, 1 output register).
- Raw low pulses shorter than DEBOUNCE cycles (after sync) produce no event.
- `prog_we` is high exactly one cycle per stored opcode.
- `prog_addr`/`prog_data` are valid in the same cycle as `prog_we` and hold until the next write.
- `count` updates on the same edge that raises `prog_we`.
- Done event at edge E:
  - `state`=FILL from E+1.
  - Fill writes occupy cycles E+1 .. E+(DEPTH-count), back-to-back.
  - `state`=DONE and `loaded`=1 from the cycle after the last fill write.
- Done event at edge E with `full`=1: DONE from E+1, with zero writes.
- `sw_op` must be stable for 2 cycles before the store event (synchronizer depth). It is sampled on the event edge only.
- Reset mid-FILL: `prog_we` drops asynchronously. The partial fill is abandoned.

## Test plan
All scenarios use DEPTH=16 and DEBOUNCE=4.
- Reset:
  - Stimulus: hold `rst`=0, toggle keys and switches.
  - Required: all outputs 0, `state`=0, no `prog_we`.
  - On release: still idle in LOAD.
- Store sequence:
  - Stimulus: press store with `sw_op`=1, then 2, then 3.
  - Required: writes (0,1), (1,2), (2,3), each `prog_we` pulse 1 cycle wide, 7 cycles after the raw edge; `count`=3.
- Glitch:
  - Stimulus: `key_store` low for 3 cycles, then high.
  - Required: no event, no write, `count` unchanged.
- Fill:
  - Stimulus: after 3 stores, press done.
  - Required: 13 consecutive writes, addresses 3..15 with data 4'hF; then `loaded`=1, `state`=2.
  - A later store press gives no write.
  - A second done press gives `state`=0, `count`=0, `loaded`=0.
- Full:
  - Stimulus: 17 store presses (data = index).
  - Required: 16 writes to addresses 0..15; `full`=1 after the 16th; the 17th is ignored.
  - A done press then gives DONE in 1 cycle with no fill writes.
- Collision and reset:
  - Stimulus: store and done debounced on the same cycle.
  - Required: no store write, FILL entered.
  - Stimulus: assert `rst` mid-FILL.
  - Required: `prog_we`=0 immediately, `count`=0, `state`=LOAD.
